vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 129 ++++++++++++
 tb/tb_vga_sync_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for a VGA-style display.
//
// Walks a pixel counter (pix_x) across H_TOTAL positions per line and a line
// counter (pix_y) across V_TOTAL lines per frame. The counters advance one
// position per clk edge on which ce is high. The block derives sync, blanking
// and line/frame markers from the counter position.
//
// Optional feature: define VGA_FRAME_COUNTER_EN to add an 8-bit frame_cnt
// output. The counter increments on every last-pixel -> 0,0 wrap.
//
// Ports:
//   clk          pixel clock; all state changes on its rising edge
//   rst          asynchronous active-high reset
//   ce           pixel-advance enable
//   pix_x        current horizontal position (0 .. H_TOTAL-1)
//   pix_y        current vertical position (0 .. V_TOTAL-1)
//   hsync        horizontal sync, active-low, registered
//   vsync        vertical sync, active-low, registered
//   display_on   high while (pix_x, pix_y) lies in the visible area
//   frame_start  high for the advance that leaves 0,0
//   line_start   high for the advance that leaves pix_x == 0
//   frame_cnt    (VGA_FRAME_COUNTER_EN only) completed-frame count, mod 256
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       frame_start,
  output logic       line_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;
  logic          hsync_next;
  logic          vsync_next;
  logic          x_wrap;
  logic          y_last;
  logic          y_over;

  // ">=" and ">" also pull any out-of-range count back to 0 on the next advance.
  assign x_wrap = (pix_x >= H_LAST);
  assign y_last = (pix_y == V_LAST);
  assign y_over = (pix_y > V_LAST);

  // Next counter position. Sync levels are decoded from this next position,
  // so the registered syncs line up with the counters they describe.
  always_comb begin
    x_next = pix_x;
    y_next = pix_y;
    if (ce) begin
      x_next = x_wrap ? '0 : pix_x + CW'(1);
      if (y_over) begin
        y_next = '0;
      end else if (x_wrap) begin
        y_next = y_last ? '0 : pix_y + CW'(1);
      end
    end
    hsync_next = !((x_next >= HS_START) && (x_next < HS_END));
    vsync_next = !((y_next >= VS_START) && (y_next < VS_END));
  end

  // Counter and sync registers. Reset discards the partial frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_x <= '0;
      pix_y <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      pix_x <= x_next;
      pix_y <= y_next;
      hsync <= hsync_next;
      vsync <= vsync_next;
    end
  end

  // Decoded straight from the counter registers. rst gates the decode
  // because the counters sit at 0,0 during reset, and these outputs must
  // stay low there without waiting for a clock.
  assign display_on  = !rst && (pix_x < H_VIS) && (pix_y < V_VIS);
  assign line_start  = ce && !rst && (pix_x == '0);
  assign frame_start = line_start && (pix_y == '0);

`ifdef VGA_FRAME_COUNTER_EN
  logic frame_wrap;

  // One count per last-pixel -> 0,0 transition; wraps naturally at 255.
  assign frame_wrap = ce && x_wrap && y_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 8'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen.
//
// dut_a uses the default 640x480 timing. It covers reset, restart, a mid-line
// reset and three full lines of horizontal timing.
//
// dut_b uses a shrunken raster with these parameters:
//   H: 4 active, 1 front porch, 2 sync, 1 back porch -> 8 per line
//   V: 3 active, 1 front porch, 2 sync, 1 back porch -> 7 lines per frame
// A frame on dut_b is 56 advances. This makes vertical timing, frame
// spacing, the last-pixel wrap with ce toggling, and frame_cnt reachable
// in a short run.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst_a, ce_a, rst_b, ce_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       hs_a, vs_a, de_a, fs_a, ls_a;
  logic       hs_b, vs_b, de_b, fs_b, ls_b;
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] fc_a, fc_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut_a (
    .clk(clk), .rst(rst_a), .ce(ce_a),
    .pix_x(x_a), .pix_y(y_a), .hsync(hs_a), .vsync(vs_a),
    .display_on(de_a), .frame_start(fs_a), .line_start(ls_a)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .ce(ce_b),
    .pix_x(x_b), .pix_y(y_b), .hsync(hs_b), .vsync(vs_b),
    .display_on(de_b), .frame_start(fs_b), .line_start(ls_b)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int   ex, ey, last_ev, gap_bad, ev_cnt, fs_cnt, fs_seen;
  int   bad_x, bad_y, bad_hs, bad_vs, bad_de, hs_low, vs_low, de_cnt;
  logic exp_hs, exp_vs, exp_de;

  initial begin
    // Reset state, with ce high so the markers' reset gating is exercised.
    rst_a = 1'b1; ce_a = 1'b1; rst_b = 1'b1; ce_b = 1'b0;
    #2;
    check("rst_x", 32'(x_a), 0);
    check("rst_y", 32'(y_a), 0);
    check("rst_hsync", 32'(hs_a), 1);
    check("rst_vsync", 32'(vs_a), 1);
    check("rst_display_on", 32'(de_a), 0);
    check("rst_frame_start", 32'(fs_a), 0);
    check("rst_line_start", 32'(ls_a), 0);
`ifdef VGA_FRAME_COUNTER_EN
    check("rst_frame_cnt", 32'(fc_a), 0);
`endif

    // Release: the first advance leaves 0,0 and carries frame_start.
    @(negedge clk); rst_a = 1'b0; #1;
    check("rel_x0", 32'(x_a), 0);
    check("rel_frame_start", 32'(fs_a), 1);
    check("rel_line_start", 32'(ls_a), 1);
    check("rel_display_on", 32'(de_a), 1);
    @(negedge clk);
    check("rel_x1", 32'(x_a), 1);
    check("rel_fs_after", 32'(fs_a), 0);
    @(negedge clk);
    check("rel_x2", 32'(x_a), 2);

    // Reset mid-line at pix_x=300: outputs go to reset values immediately.
    repeat (298) @(negedge clk);
    check("mid_x300", 32'(x_a), 300);
    #2 rst_a = 1'b1; #1;
    check("mid_rst_x", 32'(x_a), 0);
    check("mid_rst_hsync", 32'(hs_a), 1);
    check("mid_rst_display_on", 32'(de_a), 0);
    check("mid_rst_line_start", 32'(ls_a), 0);
    @(negedge clk); rst_a = 1'b0; #1;
    check("mid_rel_x0", 32'(x_a), 0);
    check("mid_rel_frame_start", 32'(fs_a), 1);
    @(negedge clk);
    check("mid_rel_x1", 32'(x_a), 1);
    @(negedge clk);
    check("mid_rel_x2", 32'(x_a), 2);

    // Reset during the hsync pulse drops it at once.
    repeat (698) @(negedge clk);
    check("hs_x700", 32'(x_a), 700);
    check("hs_low_700", 32'(hs_a), 0);
    #2 rst_a = 1'b1; #1;
    check("hs_rst_release", 32'(hs_a), 1);
    check("hs_rst_x", 32'(x_a), 0);

    // Three full lines with ce=1: horizontal timing against a position model.
    @(negedge clk); rst_a = 1'b0;
    bad_x = 0; bad_y = 0; bad_hs = 0; bad_de = 0; hs_low = 0; de_cnt = 0;
    last_ev = -1; gap_bad = 0; ev_cnt = 0; fs_cnt = 0;
    for (int k = 0; k < 2400; k++) begin
      #1;
      ex = k % 800; ey = k / 800;
      exp_hs = !(ex >= 656 && ex < 752);
      exp_de = (ex < 640) && (ey < 480);
      if (x_a !== 10'(ex)) bad_x++;
      if (y_a !== 10'(ey)) bad_y++;
      if (hs_a !== exp_hs) bad_hs++;
      if (de_a !== exp_de) bad_de++;
      if (k < 800 && hs_a === 1'b0) hs_low++;
      if (k < 800 && de_a === 1'b1) de_cnt++;
      if (fs_a === 1'b1) fs_cnt++;
      if (ls_a === 1'b1) begin
        if (last_ev >= 0 && k - last_ev != 800) gap_bad++;
        last_ev = k; ev_cnt++;
      end
      @(negedge clk);
    end
    check("line_x_track", bad_x, 0);
    check("line_y_track", bad_y, 0);
    check("line_hsync_window", bad_hs, 0);
    check("line_display_on", bad_de, 0);
    check("line_hsync_width", hs_low, 96);
    check("line_visible_count", de_cnt, 640);
    check("line_start_count", ev_cnt, 3);
    check("line_start_period", gap_bad, 0);
    check("line_frame_start_count", fs_cnt, 1);

    // Shrunken raster: three frames of vertical timing.
    @(negedge clk); rst_b = 1'b0; ce_b = 1'b1;
    bad_x = 0; bad_y = 0; bad_hs = 0; bad_vs = 0; bad_de = 0;
    vs_low = 0; de_cnt = 0; last_ev = -1; gap_bad = 0; ev_cnt = 0;
    for (int k = 0; k < 168; k++) begin
      #1;
      ex = k % 8; ey = (k / 8) % 7;
      exp_hs = !(ex >= 5 && ex < 7);
      exp_vs = !(ey >= 4 && ey < 6);
      exp_de = (ex < 4) && (ey < 3);
      if (x_b !== 10'(ex)) bad_x++;
      if (y_b !== 10'(ey)) bad_y++;
      if (hs_b !== exp_hs) bad_hs++;
      if (vs_b !== exp_vs) bad_vs++;
      if (de_b !== exp_de) bad_de++;
      if (k < 56 && vs_b === 1'b0) vs_low++;
      if (k >= 56 && k < 112 && de_b === 1'b1) de_cnt++;
      if (fs_b === 1'b1) begin
        if (last_ev >= 0 && k - last_ev != 56) gap_bad++;
        last_ev = k; ev_cnt++;
      end
      @(negedge clk);
    end
    check("frm_x_track", bad_x, 0);
    check("frm_y_track", bad_y, 0);
    check("frm_hsync_window", bad_hs, 0);
    check("frm_vsync_window", bad_vs, 0);
    check("frm_display_on", bad_de, 0);
    check("frm_vsync_width", vs_low, 16);
    check("frm_visible_count", de_cnt, 12);
    check("frm_start_count", ev_cnt, 3);
    check("frm_start_period", gap_bad, 0);

    // Last pixel with ce toggling 1,0,1,0.
    repeat (55) @(negedge clk);
    check("wrap_at_last_x", 32'(x_b), 7);
    check("wrap_at_last_y", 32'(y_b), 6);
    fs_seen = 0;
    @(negedge clk); ce_b = 1'b0; #1;
    check("wrap_x0", 32'(x_b), 0);
    check("wrap_y0", 32'(y_b), 0);
    if (fs_b === 1'b1) fs_seen++;
    @(negedge clk);
    check("wrap_hold_x", 32'(x_b), 0);
    check("wrap_hold_y", 32'(y_b), 0);
    ce_b = 1'b1; #1;
    check("wrap_frame_start", 32'(fs_b), 1);
    if (fs_b === 1'b1) fs_seen++;
    @(negedge clk); ce_b = 1'b0; #1;
    check("wrap_x1", 32'(x_b), 1);
    if (fs_b === 1'b1) fs_seen++;
    @(negedge clk);
    check("wrap_hold_x1", 32'(x_b), 1);
    check("wrap_fs_once", fs_seen, 1);

    // Hold inside the hsync pulse: levels and position frozen while ce=0.
    ce_b = 1'b1;
    repeat (4) @(negedge clk);
    ce_b = 1'b0;
    check("hold_hs_x5", 32'(x_b), 5);
    check("hold_hs_low", 32'(hs_b), 0);
    repeat (2) @(negedge clk);
    check("hold_hs_x5_after", 32'(x_b), 5);
    check("hold_hs_still_low", 32'(hs_b), 0);

`ifdef VGA_FRAME_COUNTER_EN
    // Frame counter over 257 frames: 254, 255, 0, 1.
    rst_b = 1'b1; #1;
    check("fc_rst", 32'(fc_b), 0);
    @(negedge clk); rst_b = 1'b0; ce_b = 1'b1;
    repeat (254 * 56) @(negedge clk);
    check("fc_254", 32'(fc_b), 254);
    repeat (56) @(negedge clk);
    check("fc_255", 32'(fc_b), 255);
    repeat (56) @(negedge clk);
    check("fc_0", 32'(fc_b), 0);
    repeat (56) @(negedge clk);
    check("fc_1", 32'(fc_b), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
